// File: rtl/alu_arbiter_if.sv
// Request/response/ALU bundle between the requesters, the arbiter and the ALU.
// The arbiter uses the slave modport; the requester/ALU side uses master.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [DATA_WIDTH-1:0] req0_operand1;
  logic [DATA_WIDTH-1:0] req0_operand2;
  logic [SEL_WIDTH-1:0]  req0_alusel;
  logic [DATA_WIDTH-1:0] req1_operand1;
  logic [DATA_WIDTH-1:0] req1_operand2;
  logic [SEL_WIDTH-1:0]  req1_alusel;
  logic [1:0]            resp_valid;
  logic [1:0]            resp_ready;
  logic [DATA_WIDTH-1:0] resp_result;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] alu_operand1;
  logic [DATA_WIDTH-1:0] alu_operand2;
  logic [SEL_WIDTH-1:0]  alu_sel;
  logic [DATA_WIDTH-1:0] alu_result;

  modport slave (
    input  req_valid, req0_operand1, req0_operand2, req0_alusel,
           req1_operand1, req1_operand2, req1_alusel, resp_ready, alu_result,
    output req_ready, resp_valid, resp_result, resp_err,
           alu_operand1, alu_operand2, alu_sel
  );

  modport master (
    output req_valid, req0_operand1, req0_operand2, req0_alusel,
           req1_operand1, req1_operand2, req1_alusel, resp_ready, alu_result,
    input  req_ready, resp_valid, resp_result, resp_err,
           alu_operand1, alu_operand2, alu_sel
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between the
// core execute path (requester 0) and the aux/debug path (requester 1).
//
// state | meaning
// IDLE  | no transaction held, arbitrating incoming requests
// EXEC  | ALU driven from captured operands, result captured on the edge
// RESP  | response held for the granted requester until it is consumed
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input logic        clk_i,
  input logic        rst_i,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  err_q, err_d;

  logic                  winner;
  logic                  sel_illegal;

  // Top two encodings (1110, 1111) are not decoded by the ALU.
  assign sel_illegal = (sel_q[SEL_WIDTH-1:1] == '1);

  // On a tie the requester that did not win last time gets the grant.
  assign winner = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];

  assign bus.resp_result = result_q;
  assign bus.resp_err    = err_q;

  // Next-state, handshake and ALU drive decode.
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    grant_d          = grant_q;
    op1_d            = op1_q;
    op2_d            = op2_q;
    sel_d            = sel_q;
    result_d         = result_q;
    err_d            = err_q;
    bus.req_ready    = 2'b00;
    bus.resp_valid   = 2'b00;
    bus.alu_operand1 = '0;
    bus.alu_operand2 = '0;
    bus.alu_sel      = '0;

    unique case (state_q)
      IDLE: begin
        // Gated by reset so nothing looks accepted while the block is held.
        if (!rst_i && (|bus.req_valid)) begin
          bus.req_ready[winner] = 1'b1;
          grant_d               = winner;
          last_grant_d          = winner;
          if (winner) begin
            op1_d = bus.req1_operand1;
            op2_d = bus.req1_operand2;
            sel_d = bus.req1_alusel;
          end else begin
            op1_d = bus.req0_operand1;
            op2_d = bus.req0_operand2;
            sel_d = bus.req0_alusel;
          end
          state_d = EXEC;
        end
      end

      EXEC: begin
        bus.alu_operand1 = op1_q;
        bus.alu_operand2 = op2_q;
        if (sel_illegal) begin
          bus.alu_sel = '0;
          result_d    = '0;
          err_d       = 1'b1;
        end else begin
          bus.alu_sel = sel_q;
          result_d    = bus.alu_result;
          err_d       = 1'b0;
        end
        state_d = RESP;
      end

      RESP: begin
        bus.resp_valid[grant_q] = 1'b1;
        if (bus.resp_ready[grant_q]) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      sel_q        <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      sel_q        <= sel_d;
      result_q     <= result_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes expected responses into a
// queue, an independent monitor pops and compares on each response handshake.
module tb_alu_arbiter;

  logic clk;
  logic rst;

  alu_arbiter_if #(.DATA_WIDTH(32), .SEL_WIDTH(4)) bus ();

  alu_arbiter #(.DATA_WIDTH(32), .SEL_WIDTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; unknown encodings return a poison value.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] sel);
    case (sel)
      4'b0000: alu_f = a + b;
      4'b0001: alu_f = a - b;
      4'b0010: alu_f = a & b;
      4'b0011: alu_f = a | b;
      4'b0100: alu_f = a ^ b;
      4'b0101: alu_f = a << b[4:0];
      4'b0110: alu_f = a >> b[4:0];
      default: alu_f = 32'hDEADBEEF;
    endcase
  endfunction

  always_comb bus.alu_result = alu_f(bus.alu_operand1, bus.alu_operand2, bus.alu_sel);

  typedef struct {
    logic        g;
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic push(input logic g, input logic [31:0] res, input logic err);
    exp_t e;
    e.g = g; e.res = res; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Both requesters held valid; grants must alternate starting from 0.
  task automatic contend(input int n);
    int k;
    k = 0;
    for (int c = 0; c < 40 && k < n; c++) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        chk("grant", {30'd0, bus.req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
        k++;
      end
      @(negedge clk);
    end
    if (k < n) chk("grant_count", k, n);
    bus.req_valid = 2'b00;
  endtask

  // Monitor: compare on each completed response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if ((bus.resp_valid & bus.resp_ready) != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", {30'd0, bus.resp_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_valid", {30'd0, bus.resp_valid}, e.g ? 32'd2 : 32'd1);
          chk("resp_result", bus.resp_result, e.res);
          chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin
    rst               = 1'b1;
    bus.req_valid     = 2'b11;
    bus.resp_ready    = 2'b00;
    bus.req0_operand1 = 32'd10;
    bus.req0_operand2 = 32'd3;
    bus.req0_alusel   = 4'b0001;
    bus.req1_operand1 = 32'd1;
    bus.req1_operand2 = 32'd4;
    bus.req1_alusel   = 4'b0101;

    // Reset: requests present but nothing accepted, outputs cleared.
    idle(2);
    #1;
    chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {30'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_result", bus.resp_result, 32'd0);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_alu_sel", {28'd0, bus.alu_sel}, 32'd0);

    // Contention fairness: 0,1,0,1 with results 7,16,7,16.
    @(negedge clk);
    rst            = 1'b0;
    bus.resp_ready = 2'b11;
    for (int i = 0; i < 4; i++) push(i[0], i[0] ? 32'd16 : 32'd7, 1'b0);
    contend(4);
    idle(3);

    // Single op: req0 ADD 5+7.
    bus.req0_operand1 = 32'd5;
    bus.req0_operand2 = 32'd7;
    bus.req0_alusel   = 4'b0000;
    bus.req_valid     = 2'b01;
    push(1'b0, 32'd12, 1'b0);
    #1 chk("single_req_ready", {30'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    chk("single_exec_rv", {30'd0, bus.resp_valid}, 32'd0);
    chk("single_alu_op1", bus.alu_operand1, 32'd5);
    chk("single_alu_op2", bus.alu_operand2, 32'd7);
    chk("single_alu_sel", {28'd0, bus.alu_sel}, 32'd0);
    @(negedge clk);
    #1;
    chk("single_resp_rv", {30'd0, bus.resp_valid}, 32'd1);
    chk("single_resp_alu_op1", bus.alu_operand1, 32'd0);
    @(negedge clk);
    #1 chk("single_idle_rv", {30'd0, bus.resp_valid}, 32'd0);

    // Back-pressure: req1 XOR held while req0 waits.
    @(negedge clk);
    bus.resp_ready    = 2'b00;
    bus.req1_operand1 = 32'hFF;
    bus.req1_operand2 = 32'h0F;
    bus.req1_alusel   = 4'b0100;
    bus.req_valid     = 2'b10;
    push(1'b1, 32'hF0, 1'b0);
    #1 chk("bp_req_ready1", {30'd0, bus.req_ready}, 32'd2);
    @(negedge clk);
    bus.req0_operand1 = 32'd1;
    bus.req0_operand2 = 32'd2;
    bus.req0_alusel   = 4'b0000;
    bus.req_valid     = 2'b01;
    push(1'b0, 32'd3, 1'b0);
    #1 chk("bp_exec_req_ready", {30'd0, bus.req_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_hold_rv", {30'd0, bus.resp_valid}, 32'd2);
      chk("bp_hold_result", bus.resp_result, 32'hF0);
      chk("bp_hold_req_ready", {30'd0, bus.req_ready}, 32'd0);
    end
    @(negedge clk);
    bus.resp_ready = 2'b11;
    @(negedge clk);
    #1 chk("bp_release_accept", {30'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    idle(3);

    // Illegal sel: result zeroed, error flagged, ALU sel kept at 0000.
    bus.req0_operand1 = 32'd3;
    bus.req0_operand2 = 32'd4;
    bus.req0_alusel   = 4'b1110;
    bus.req_valid     = 2'b01;
    push(1'b0, 32'd0, 1'b1);
    #1 chk("ill_req_ready", {30'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    chk("ill_exec_alu_sel", {28'd0, bus.alu_sel}, 32'd0);
    chk("ill_exec_alu_op1", bus.alu_operand1, 32'd3);
    @(negedge clk);
    #1;
    chk("ill_resp_alu_sel", {28'd0, bus.alu_sel}, 32'd0);
    chk("ill_resp_err", {31'd0, bus.resp_err}, 32'd1);
    idle(3);

    // Reset mid-op: ADD dropped in EXEC, then a tie grants 0 first.
    bus.req0_operand1 = 32'd2;
    bus.req0_operand2 = 32'd2;
    bus.req0_alusel   = 4'b0000;
    bus.req_valid     = 2'b01;
    #1 chk("rstop_req_ready", {30'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    rst               = 1'b1;
    bus.req_valid     = 2'b11;
    bus.req0_operand1 = 32'd10;
    bus.req0_operand2 = 32'd3;
    bus.req0_alusel   = 4'b0001;
    bus.req1_operand1 = 32'd1;
    bus.req1_operand2 = 32'd4;
    bus.req1_alusel   = 4'b0101;
    @(negedge clk);
    #1;
    chk("rstop_held_req_ready", {30'd0, bus.req_ready}, 32'd0);
    chk("rstop_resp_valid", {30'd0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push(1'b0, 32'd7, 1'b0);
    push(1'b1, 32'd16, 1'b0);
    contend(2);

    // Drain outstanding expectations with a bound.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 32'd0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
